// File: rtl/dwell_arbiter_pkg.sv
// Shared types and helpers for the dwell arbiter: FSM state encoding and a constant clog2.
package dwell_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StOwn
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dwell_arbiter_if.sv
// Request/grant bundle between requesters (master) and the dwell arbiter (slave).
interface dwell_arbiter_if
    import dwell_arbiter_pkg::*;
#(
    parameter int unsigned width = 4
);
    localparam int unsigned IdxW = clog2(width);

    logic [width-1:0] req;
    logic [width-1:0] grant;
    logic [IdxW-1:0]  grant_index;
    logic             valid;
    logic             locked;

    modport master (
        output req,
        input  grant,
        input  grant_index,
        input  valid,
        input  locked
    );

    modport slave (
        input  req,
        output grant,
        output grant_index,
        output valid,
        output locked
    );

endinterface

// File: rtl/dwell_arbiter_rr_select.sv
// Combinational round-robin pick: first asserted req scanning last+1, last+2, ... modulo width.
module dwell_arbiter_rr_select
    import dwell_arbiter_pkg::*;
#(
    parameter int unsigned width = 4,
    localparam int unsigned IdxW = clog2(width)
) (
    input  logic [width-1:0] req,
    input  logic [IdxW-1:0]  last,
    output logic             any,
    output logic [IdxW-1:0]  pick
);

    logic [IdxW-1:0] idx;

    // Scan farthest offset first so the nearest candidate is the one left standing.
    always_comb begin
        any  = 1'b0;
        pick = '0;
        idx  = '0;
        for (int i = int'(width); i >= 1; i--) begin
            idx = IdxW'((int'(last) + i) % int'(width));
            if (req[idx]) begin
                any  = 1'b1;
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/dwell_arbiter.sv
// Round-robin arbiter with a minimum grant dwell of min_count enable ticks.
// Optional ARB_MAX_GRANT_EN: preempt an owner after max_count ticks when others are waiting.
module dwell_arbiter
    import dwell_arbiter_pkg::*;
#(
    parameter int unsigned width     = 4,
    parameter int unsigned min_count = 4,
    parameter int unsigned max_count = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    dwell_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = clog2(width);
    localparam int unsigned CntW = clog2(max_count) + 1;

    state_e           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d, count_inc;
    logic [IdxW-1:0]  last_q, last_d;
    logic [width-1:0] grant_q, grant_d;
    logic [IdxW-1:0]  index_q, index_d;
    logic             valid_q, valid_d;
    logic [width-1:0] sel_req;
    logic             sel_any;
    logic [IdxW-1:0]  sel_pick;

    // In OWN the current owner is masked so sel_any means "someone else is waiting".
    assign sel_req = (state_q == StOwn) ? (bus.req & ~grant_q) : bus.req;

    dwell_arbiter_rr_select #(
        .width (width)
    ) u_rr_select (
        .req  (sel_req),
        .last (last_q),
        .any  (sel_any),
        .pick (sel_pick)
    );

    assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        grant_d = grant_q;
        index_d = index_q;
        unique case (state_q)
            StIdle: begin
                if (sel_any) begin
                    state_d = StHold;
                    count_d = '0;
                    last_d  = sel_pick;
                    grant_d = width'(1) << sel_pick;
                    index_d = sel_pick;
                end
            end
            StHold: begin
                if (enable) begin
                    count_d = count_inc;
                    if (count_q == CntW'(min_count - 1)) begin
                        state_d = StOwn;
                    end
                end
            end
            StOwn: begin
                if (!bus.req[last_q]) begin
                    if (sel_any) begin
                        state_d = StHold;
                        count_d = '0;
                        last_d  = sel_pick;
                        grant_d = width'(1) << sel_pick;
                        index_d = sel_pick;
                    end else begin
                        state_d = StIdle;
                        count_d = '0;
                        grant_d = '0;
                        index_d = '0;
                    end
                end
`ifdef ARB_MAX_GRANT_EN
                else if (enable) begin
                    if (sel_any && (count_q >= CntW'(max_count - 1))) begin
                        state_d = StHold;
                        count_d = '0;
                        last_d  = sel_pick;
                        grant_d = width'(1) << sel_pick;
                        index_d = sel_pick;
                    end else begin
                        count_d = count_inc;
                    end
                end
`endif
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
                grant_d = '0;
                index_d = '0;
            end
        endcase
        valid_d = |grant_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            last_q  <= IdxW'(width - 1);
            grant_q <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            index_q <= index_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_index = index_q;
    assign bus.valid       = valid_q;
    assign bus.locked      = (state_q == StHold);

endmodule

// File: tb/tb_dwell_arbiter.sv
// Directed self-checking bench for dwell_arbiter (width=4, min_count=4, max_count=16).
module tb_dwell_arbiter;

    logic clock;
    logic reset;
    logic enable;
    int   checks;
    int   failures;

    dwell_arbiter_if #(.width(4)) arb_bus ();

    dwell_arbiter #(
        .width     (4),
        .min_count (4),
        .max_count (16)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .bus    (arb_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                             input logic v, input logic lk);
        check({tag, ".grant"}, 32'(arb_bus.grant), 32'(g));
        check({tag, ".index"}, 32'(arb_bus.grant_index), 32'(idx));
        check({tag, ".valid"}, 32'(arb_bus.valid), 32'(v));
        check({tag, ".locked"}, 32'(arb_bus.locked), 32'(lk));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        arb_bus.req = 4'b0000;
        step();
        step();
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 1: first grant goes to requester 0 with latency 1
        reset       = 1'b0;
        arb_bus.req = 4'b0101;
        step();
        check_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b1);

        // 2: dwell holds grant 0 despite the early drop, then hands over to 2
        arb_bus.req = 4'b0100;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("dwell%0d.grant", k), 32'(arb_bus.grant), 32'h1);
        end
        check("dwell4.locked", 32'(arb_bus.locked), 32'h0);
        step();
        check_out("handover", 4'b0100, 2'd2, 1'b1, 1'b1);

        // 3: without enable the hold never expires
        enable      = 1'b0;
        arb_bus.req = 4'b0000;
        for (int k = 0; k < 20; k++) step();
        check_out("stall", 4'b0100, 2'd2, 1'b1, 1'b1);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("stall_own.locked", 32'(arb_bus.locked), 32'h0);
        step();
        check_out("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 4: wrap-around from owner 3 to requester 0, then back to 3
        arb_bus.req = 4'b1000;
        step();
        check_out("grant3", 4'b1000, 2'd3, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step();
        arb_bus.req = 4'b0001;
        step();
        check_out("wrap0", 4'b0001, 2'd0, 1'b1, 1'b1);
        arb_bus.req = 4'b1000;
        for (int k = 0; k < 4; k++) step();
        check("wrap_own.grant", 32'(arb_bus.grant), 32'h1);
        step();
        check_out("back3", 4'b1000, 2'd3, 1'b1, 1'b1);
        arb_bus.req = 4'b0000;
        for (int k = 0; k < 5; k++) step();
        check("idle2.valid", 32'(arb_bus.valid), 32'h0);

        // 5: two constant requesters; preemption only with the max-tenure feature
        arb_bus.req = 4'b0011;
        step();
        check("tenure0.grant", 32'(arb_bus.grant), 32'h1);
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 15 || k == 16 || k == 31 || k == 32) begin
`ifdef ARB_MAX_GRANT_EN
                check($sformatf("tenure%0d.grant", k), 32'(arb_bus.grant),
                      (k == 16 || k == 31) ? 32'h2 : 32'h1);
`else
                check($sformatf("tenure%0d.grant", k), 32'(arb_bus.grant), 32'h1);
`endif
            end
        end

        // 6: asynchronous reset in the middle of a hold
        reset = 1'b1;
        step();
        reset       = 1'b0;
        arb_bus.req = 4'b0010;
        step();
        step();
        check("midhold.locked", 32'(arb_bus.locked), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        arb_bus.req = 4'b1111;
        step();
        reset = 1'b0;
        step();
        check_out("after_reset", 4'b0001, 2'd0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
